// File: rtl/hazard_forward_unit.sv
// Forwarding and load-use hazard unit for the 5-stage pipeline: shadows EX/MEM destinations, emits registered ALU selects.
// Optional HAZARD_STALL_EN adds the load-use stall and its saturating stall counter; without it stall/stall_count are 0.
module hazard_forward_unit #(
    parameter int REG_ADDR_W = 3,
    parameter bit ZERO_REG   = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs_a_i,
    input  logic                  id_use_a_i,
    input  logic [REG_ADDR_W-1:0] id_rs_b_i,
    input  logic                  id_use_b_i,
    input  logic                  id_alu_b_imm_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_reg_write_i,
    input  logic                  id_mem_read_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic [1:0]            forward_a_o,
    output logic [1:0]            forward_b_o,
    output logic [CNT_W-1:0]      stall_count_o
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_IMM = 2'b01;
    localparam logic [1:0] SEL_EX  = 2'b10;
    localparam logic [1:0] SEL_MEM = 2'b11;

    logic                  ex_v_q, ex_v_d;
    logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
    logic                  mem_v_q;
    logic [REG_ADDR_W-1:0] mem_rd_q;
    logic [1:0]            fwd_a_q, fwd_a_d;
    logic [1:0]            fwd_b_q, fwd_b_d;
    logic                  a_ex_s, a_mem_s, b_ex_s, b_mem_s;
    logic                  id_live_s;
    logic                  stall_s;

    // A hardwired-zero r0 never carries a real producer, so it never matches.
    function automatic logic src_match(input logic use_src, input logic [REG_ADDR_W-1:0] rs,
                                       input logic stage_v, input logic [REG_ADDR_W-1:0] stage_rd);
        return use_src & stage_v & (rs == stage_rd) &
               ~(ZERO_REG & (rs == {REG_ADDR_W{1'b0}}));
    endfunction

    // Source/producer comparisons against the shadow EX and MEM state.
    always_comb begin
        id_live_s = id_valid_i & ~flush_i;
        a_ex_s    = src_match(id_use_a_i, id_rs_a_i, ex_v_q,  ex_rd_q);
        a_mem_s   = src_match(id_use_a_i, id_rs_a_i, mem_v_q, mem_rd_q);
        b_ex_s    = src_match(id_use_b_i, id_rs_b_i, ex_v_q,  ex_rd_q);
        b_mem_s   = src_match(id_use_b_i, id_rs_b_i, mem_v_q, mem_rd_q);
    end

`ifdef HAZARD_STALL_EN
    logic             ex_ld_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Load-use stall; a B match is irrelevant when B takes the immediate.
    always_comb begin
        stall_s = id_live_s & ex_v_q & ex_ld_q & (a_ex_s | (b_ex_s & ~id_alu_b_imm_i));
        if (stall_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Load flag of the EX-stage producer and the saturating stall counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_ld_q <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            ex_ld_q <= id_mem_read_i;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_count_o = cnt_q;
`else
    logic unused_mem_read_s;

    assign unused_mem_read_s = id_mem_read_i;
    assign stall_s           = 1'b0;
    assign stall_count_o     = {CNT_W{1'b0}};
`endif

    // Next-cycle selects and EX shadow entry; flush and stall both inject a bubble.
    always_comb begin
        ex_v_d  = id_valid_i & id_reg_write_i & ~stall_s & ~flush_i;
        ex_rd_d = id_rd_i;
        if (flush_i || stall_s) begin
            fwd_a_d = SEL_RF;
            fwd_b_d = SEL_RF;
        end else begin
            if (a_ex_s) begin
                fwd_a_d = SEL_EX;
            end else if (a_mem_s) begin
                fwd_a_d = SEL_MEM;
            end else begin
                fwd_a_d = SEL_RF;
            end
            if (id_alu_b_imm_i) begin
                fwd_b_d = SEL_IMM;
            end else if (b_ex_s) begin
                fwd_b_d = SEL_EX;
            end else if (b_mem_s) begin
                fwd_b_d = SEL_MEM;
            end else begin
                fwd_b_d = SEL_RF;
            end
        end
    end

    // Shadow pipeline state and registered operand selects.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_v_q   <= 1'b0;
            ex_rd_q  <= {REG_ADDR_W{1'b0}};
            mem_v_q  <= 1'b0;
            mem_rd_q <= {REG_ADDR_W{1'b0}};
            fwd_a_q  <= SEL_RF;
            fwd_b_q  <= SEL_RF;
        end else begin
            ex_v_q   <= ex_v_d;
            ex_rd_q  <= ex_rd_d;
            mem_v_q  <= ex_v_q;
            mem_rd_q <= ex_rd_q;
            fwd_a_q  <= fwd_a_d;
            fwd_b_q  <= fwd_b_d;
        end
    end

    assign stall_o     = stall_s;
    assign forward_a_o = fwd_a_q;
    assign forward_b_o = fwd_b_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Table-driven bench for hazard_forward_unit; expectations cover both HAZARD_STALL_EN builds.
module tb_hazard_forward_unit;

`ifdef HAZARD_STALL_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_use_a, id_use_b, id_imm, id_rw, id_mr, flush;
    logic [2:0] id_rs_a, id_rs_b, id_rd;
    logic       stall, stall2;
    logic [1:0] fwd_a, fwd_b, fwd_a2, fwd_b2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       vld, ua, ub, imm, rw, mr, fl;
        logic [2:0] ra, rb, rd;
        logic       st;
        logic [1:0] fa, fb, fa_n, fb_n;
        int         cnt;
    } vec_t;

    vec_t tbl[24];

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_ADDR_W(3), .ZERO_REG(1'b1), .CNT_W(16)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid),
        .id_rs_a_i(id_rs_a), .id_use_a_i(id_use_a), .id_rs_b_i(id_rs_b), .id_use_b_i(id_use_b),
        .id_alu_b_imm_i(id_imm), .id_rd_i(id_rd), .id_reg_write_i(id_rw), .id_mem_read_i(id_mr),
        .flush_i(flush), .stall_o(stall), .forward_a_o(fwd_a), .forward_b_o(fwd_b),
        .stall_count_o(cnt)
    );

    hazard_forward_unit #(.REG_ADDR_W(3), .ZERO_REG(1'b1), .CNT_W(2)) u_sat (
        .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid),
        .id_rs_a_i(id_rs_a), .id_use_a_i(id_use_a), .id_rs_b_i(id_rs_b), .id_use_b_i(id_use_b),
        .id_alu_b_imm_i(id_imm), .id_rd_i(id_rd), .id_reg_write_i(id_rw), .id_mem_read_i(id_mr),
        .flush_i(flush), .stall_o(stall2), .forward_a_o(fwd_a2), .forward_b_o(fwd_b2),
        .stall_count_o(cnt2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int vld, input int ra, input int ua, input int rb, input int ub,
                                input int imm, input int rd, input int rw, input int mr, input int fl,
                                input int st, input int fa, input int fb, input int fan, input int fbn,
                                input int c);
        vec_t m;
        m.vld = vld[0]; m.ra = ra[2:0]; m.ua = ua[0]; m.rb = rb[2:0]; m.ub = ub[0];
        m.imm = imm[0]; m.rd = rd[2:0]; m.rw = rw[0]; m.mr = mr[0]; m.fl = fl[0];
        m.st = st[0]; m.fa = fa[1:0]; m.fb = fb[1:0]; m.fa_n = fan[1:0]; m.fb_n = fbn[1:0];
        m.cnt = c;
        return m;
    endfunction

    task automatic drive(input int vld, input int ra, input int ua, input int rb, input int ub,
                         input int imm, input int rd, input int rw, input int mr, input int fl);
        id_valid = vld[0]; id_rs_a = ra[2:0]; id_use_a = ua[0]; id_rs_b = rb[2:0];
        id_use_b = ub[0]; id_imm = imm[0]; id_rd = rd[2:0]; id_rw = rw[0];
        id_mr = mr[0]; flush = fl[0];
    endtask

    task automatic apply(input vec_t v, input int idx);
        drive(v.vld, v.ra, v.ua, v.rb, v.ub, v.imm, v.rd, v.rw, v.mr, v.fl);
        @(negedge clk);
        check($sformatf("stall[%0d]", idx), stall, EN ? v.st : 1'b0);
        check($sformatf("sat_stall[%0d]", idx), stall2, EN ? v.st : 1'b0);
        @(posedge clk); #1;
        check($sformatf("fwd_a[%0d]", idx), fwd_a, EN ? v.fa : v.fa_n);
        check($sformatf("fwd_b[%0d]", idx), fwd_b, EN ? v.fb : v.fb_n);
        check($sformatf("cnt[%0d]", idx), cnt, EN ? v.cnt : 0);
        check($sformatf("sat_cnt[%0d]", idx), cnt2, EN ? v.cnt : 0);
    endtask

    // LW r4 followed by ADD r5 = r4 + r4 presented twice (stall cycle, then the held copy).
    task automatic load_use_pair(input int k);
        drive(1, 0, 1, 0, 0, 1, 4, 1, 1, 0);
        @(posedge clk); #1;
        drive(1, 4, 1, 4, 1, 0, 5, 1, 0, 0);
        @(negedge clk);
        check($sformatf("lu_stall[%0d]", k), stall, EN);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check($sformatf("lu_fwd_a[%0d]", k), fwd_a, 2'b11);
        check($sformatf("lu_fwd_b[%0d]", k), fwd_b, 2'b11);
    endtask

    initial begin
        //            vld ra ua rb ub imm rd rw mr fl  st fa fb fan fbn cnt
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 2, 1, 3, 1, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 1, 1, 3, 1, 0, 2, 1, 0, 0,  0, 2, 0, 2, 0, 0);
        tbl[3]  = mk(1, 5, 1, 6, 1, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 5, 1, 6, 1, 0, 7, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 1, 1, 7, 1, 0, 3, 1, 0, 0,  0, 3, 2, 3, 2, 0);
        tbl[6]  = mk(1, 3, 1, 7, 1, 0, 3, 1, 0, 0,  0, 2, 3, 2, 3, 0);
        tbl[7]  = mk(1, 3, 1, 0, 1, 0, 5, 1, 0, 0,  0, 2, 0, 2, 0, 0);
        tbl[8]  = mk(1, 5, 1, 0, 0, 1, 4, 1, 1, 0,  0, 2, 1, 2, 1, 0);
        tbl[9]  = mk(1, 4, 1, 4, 1, 0, 5, 1, 0, 0,  1, 0, 0, 2, 2, 1);
        tbl[10] = mk(1, 4, 1, 4, 1, 0, 5, 1, 0, 0,  0, 3, 3, 3, 3, 1);
        tbl[11] = mk(1, 5, 1, 5, 1, 1, 6, 1, 0, 0,  0, 2, 1, 2, 1, 1);
        tbl[12] = mk(1, 6, 1, 6, 1, 0, 0, 1, 0, 0,  0, 2, 2, 2, 2, 1);
        tbl[13] = mk(1, 0, 1, 0, 1, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 1);
        tbl[14] = mk(1, 0, 1, 0, 0, 1, 0, 1, 1, 0,  0, 0, 1, 0, 1, 1);
        tbl[15] = mk(1, 0, 1, 0, 1, 0, 2, 1, 0, 0,  0, 0, 0, 0, 0, 1);
        tbl[16] = mk(1, 2, 1, 0, 0, 1, 4, 1, 1, 0,  0, 2, 1, 2, 1, 1);
        tbl[17] = mk(1, 4, 1, 1, 1, 0, 5, 1, 0, 1,  0, 0, 0, 0, 0, 1);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        tbl[19] = mk(1, 0, 1, 0, 0, 1, 3, 1, 1, 0,  0, 0, 1, 0, 1, 1);
        tbl[20] = mk(1, 1, 1, 3, 1, 0, 6, 1, 0, 0,  1, 0, 0, 0, 2, 2);
        tbl[21] = mk(1, 1, 1, 3, 1, 0, 6, 1, 0, 0,  0, 0, 3, 0, 3, 2);
        tbl[22] = mk(1, 0, 1, 0, 0, 1, 4, 1, 1, 0,  0, 0, 1, 0, 1, 2);
        tbl[23] = mk(1, 0, 1, 4, 1, 1, 5, 1, 0, 0,  0, 0, 1, 0, 1, 2);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", stall, 1'b0);
        check("rst_fwd_a", fwd_a, 2'b00);
        check("rst_fwd_b", fwd_b, 2'b00);
        check("rst_cnt", cnt, 16'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            apply(tbl[i], i);
        end

        for (int k = 0; k < 3; k++) begin
            load_use_pair(k);
        end
        check("cnt_total", cnt, EN ? 16'd5 : 16'd0);
        check("cnt_saturated", cnt2, EN ? 2'd3 : 2'd0);

        // Reset asserted while a load-use stall is being signalled.
        drive(1, 0, 1, 0, 0, 1, 4, 1, 1, 0);
        @(posedge clk); #1;
        check("pre_rst_fwd_b", fwd_b, 2'b01);
        drive(1, 4, 1, 4, 1, 0, 5, 1, 0, 0);
        #2;
        check("pre_rst_stall", stall, EN);
        rst_n = 1'b0;
        #1;
        check("mid_rst_stall", stall, 1'b0);
        check("mid_rst_fwd_a", fwd_a, 2'b00);
        check("mid_rst_fwd_b", fwd_b, 2'b00);
        check("mid_rst_cnt", cnt, 16'd0);
        check("mid_rst_sat_cnt", cnt2, 2'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_stall", stall, 1'b0);
        @(posedge clk); #1;
        check("post_rst_fwd_a", fwd_a, 2'b00);
        check("post_rst_fwd_b", fwd_b, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised forwarding and hazard unit for the 5-stage pipelined processor, replacing the hardwired selects (forward_A = 00, forward_B = {0, ID_EX_alu_B_mux}). It keeps its own shadow copy of the EX and MEM destination-register state and compares it against the sources decoded in ID. Each cycle it produces registered ALU operand selects that align with the ID/EX register, a combinational load-use stall, and a saturating stall counter for performance monitoring.

## Interface
- REG_ADDR_W, 3: register address width (2^REG_ADDR_W registers).
- ZERO_REG, 1: 1 = register 0 is hardwired zero and is never forwarded or stalled on; 0 = register 0 is ordinary.
- CNT_W, 16: stall counter width.

- clk  in  1  processor clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- id_valid  in  1  the ID stage holds a real instruction.
- id_rs_a  in  REG_ADDR_W  source register for ALU operand A.
- id_use_a  in  1  the instruction reads id_rs_a.
- id_rs_b  in  REG_ADDR_W  source register for ALU operand B.
- id_use_b  in  1  the instruction reads id_rs_b.
- id_alu_b_imm  in  1  operand B is the immediate.
- id_rd  in  REG_ADDR_W  destination register.
- id_reg_write  in  1  the instruction writes id_rd.
- id_mem_read  in  1  the instruction is a load.
- flush  in  1  taken branch/jump; the ID instruction is squashed.
- stall  out  1  combinational; holds PC and IF/ID and forces a bubble into ID/EX.
- forward_a  out  2  registered EX select for operand A.
- forward_b  out  2  registered EX select for operand B.
- stall_count  out  CW  saturating count of stall cycles.

## Operation
- Select encoding: 00 = register file, 01 = immediate (operand B only), 10 = EX/MEM ALU result, 11 = MEM/WB result (ALU or load data).
- Shadow state: ex_v/ex_rd/ex_ld and mem_v/mem_rd.
  - EX entry: ex_v = id_valid & id_reg_write & ~stall & ~flush.
  - MEM entry: copied from the EX state every cycle.
- ID is "live" when id_valid = 1 and flush = 0.
- A source matches when its use bit = 1, the register address is equal, the stage valid bit = 1, and not (ZERO_REG = 1 and the address = 0).
- Next forward_a: 10 if it matches EX; else 11 if it matches MEM; else 00. The youngest producer wins.
- Next forward_b: 01 if id_alu_b_imm = 1, which overrides any match; otherwise the same rule as forward_a.
- Load-use stall: stall = ID live & ex_v & ex_ld & (A matches EX, or B matches EX with id_alu_b_imm = 0).
- During a stall:
  - the next forward_a and forward_b are 00 (bubble);
  - the EX state becomes invalid;
  - the MEM state takes the load.
  - In the following cycle the consumer sees the load in MEM and selects 11.
- Flush has priority over stall: stall = 0, next forwards = 00, and the next EX state is invalid.
- The register file writes before it reads (write-first), so WB-stage producers need no forwarding.
- stall_count increments on every cycle with stall = 1 and saturates at all-ones.

## Timing
- Reset values: forward_a = 00, forward_b = 00, stall = 0, stall_count = 0, and all shadow valid bits = 0. Reset clears state asynchronously on assertion; release is synchronised by the top level.
- Latency: a forward select is computed in ID and is visible on forward_a/forward_b exactly one cycle later, during EX.
- stall is combinational from the ID inputs and the EX shadow state. It is asserted for exactly one cycle per load-use pair.
- Reset asserted mid-stall: stall drops immediately because all valid bits clear; no hazard is carried across reset.

## Configuration
- HAZARD_STALL_EN
  - Defined: the load-use stall logic and stall_count are present as described.
  - Undefined: stall is tied to 0 and stall_count to 0. The software toolchain must insert a NOP after each load. A load still forwards as 10 if used back-to-back, which is architecturally undefined.

## Test plan
- Reset: drive reset = 0 mid-run -> all outputs are 0 within the same cycle.
- ALU back-to-back:
  - ADD r1 then SUB r2 = r1 - r3 -> forward_a = 10 in the SUB's EX cycle.
  - Same sequence with an independent instruction between the ADD and the SUB -> forward_a = 11.
- Load-use:
  - LW r4, then ADD r5 = r4 + r4 -> stall = 1 for one cycle.
  - Next cycle: forward_a = 00 and forward_b = 00 (bubble in EX).
  - Following EX cycle: forward_a = 11 and forward_b = 11.
  - stall_count = 1.
- Immediate and zero register:
  - ADDI r6 = r1 + 5 directly after a producer of r1 -> forward_a = 10 and forward_b = 01.
  - With ZERO_REG = 1, an instruction writing r0 followed by a reader of r0 -> selects 00 and no stall.
- Flush and stall together: load-use pair with flush = 1 in the stall cycle -> stall = 0, next forwards = 00, and stall_count unchanged.
- Saturation: CNT_W = 2 with 5 load-use stalls -> stall_count = 3.
